// File: rtl/dma_read_engine_if.sv
// Bus bundle for the DMA read engine: AXI4 read address/data channels plus the
// outgoing word stream. "master" is the engine side, "slave" the memory/sink side.
interface dma_read_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/dma_read_engine.sv
// Single-outstanding-burst AXI4 read DMA: splits a byte range into INCR bursts that
// never cross 4 KB and forwards every returned word through a one-entry stream register.
module dma_read_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
    input  logic [31:0]           cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    dma_read_engine_if.master     bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [29:0]           rem_q, rem_d;
    logic [8:0]            burst_q, burst_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic [29:0]           next_rem_s;
    logic [8:0]            start_burst_s;
    logic [8:0]            next_burst_s;
    logic                  last_in_burst_s;
    logic                  final_beat_s;
    logic                  rready_s;
    logic                  rbeat_s;
    logic                  beat_bad_s;
    logic                  cfg_len_unused_s;

    // Beats for the next burst: min(remaining, MAX_BURST, words left in this 4 KB page).
    function automatic logic [8:0] burst_beats(input logic [9:0] word_off, input logic [29:0] rem);
        logic [10:0] to_4k;
        logic [10:0] cap;
        to_4k = 11'd1024 - {1'b0, word_off};
        cap   = (to_4k < 11'(MAX_BURST)) ? to_4k : 11'(MAX_BURST);
        return ({19'd0, cap} > rem) ? rem[8:0] : cap[8:0];
    endfunction

    assign cfg_len_unused_s = ^cfg_len[1:0];
    assign start_burst_s    = burst_beats(cfg_src_addr[11:2], cfg_len[31:2]);
    assign next_addr_s      = addr_q + {{(ADDR_WIDTH-11){1'b0}}, burst_q, 2'b00};
    assign next_rem_s       = rem_q - {21'd0, burst_q};
    assign next_burst_s     = burst_beats(next_addr_s[11:2], next_rem_s);
    assign last_in_burst_s  = (beat_cnt_q == burst_q - 9'd1);
    assign final_beat_s     = last_in_burst_s && (rem_q == {21'd0, burst_q});
    assign rready_s         = (state_q == DATA) && (!tvalid_q || bus.m_axis_tready);
    assign rbeat_s          = rready_s && bus.m_axi_rvalid;
    // Error response or an rlast that disagrees with our own beat count.
    assign beat_bad_s       = (bus.m_axi_rresp != 2'b00) || (bus.m_axi_rlast != last_in_burst_s);

    // Next-state, burst bookkeeping and output-register logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        araddr_d   = araddr_q;
        rem_d      = rem_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        arlen_d    = arlen_q;
        arvalid_d  = arvalid_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;

        if (tvalid_q && bus.m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    if (cfg_len[31:2] == 30'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ADDR;
                        addr_d     = cfg_src_addr;
                        rem_d      = cfg_len[31:2];
                        burst_d    = start_burst_s;
                        beat_cnt_d = 9'd0;
                        arvalid_d  = 1'b1;
                        araddr_d   = cfg_src_addr;
                        arlen_d    = 8'(start_burst_s - 9'd1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (bus.m_axi_arready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = 9'd0;
                    state_d    = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (rbeat_s) begin
                    tvalid_d = 1'b1;
                    tdata_d  = bus.m_axi_rdata;
                    tlast_d  = final_beat_s;
                    if (beat_bad_s) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                    if (last_in_burst_s) begin
                        addr_d     = next_addr_s;
                        rem_d      = next_rem_s;
                        beat_cnt_d = 9'd0;
                        if (next_rem_s != 30'd0) begin
                            state_d   = ADDR;
                            burst_d   = next_burst_s;
                            arvalid_d = 1'b1;
                            araddr_d  = next_addr_s;
                            arlen_d   = 8'(next_burst_s - 9'd1);
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            DONE: begin
                // Completion is only signalled once the last word has left the register.
                if (!tvalid_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            araddr_q   <= '0;
            rem_q      <= 30'd0;
            burst_q    <= 9'd0;
            beat_cnt_q <= 9'd0;
            arlen_q    <= 8'd0;
            arvalid_q  <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            araddr_q   <= araddr_d;
            rem_q      <= rem_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            arlen_q    <= arlen_d;
            arvalid_q  <= arvalid_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_s;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule
